// File: rtl/laser_point_sequencer.sv
// laser_point_sequencer: walks a point buffer frame by frame, hands each
// point to a DAC driver, waits for the transfer, then dwells on it.
// Optional feature macro: BLANK_ON_JUMP_EN. When defined, a point that is
// far from the previous one is first sent dark, held for a dwell period so
// the galvos can settle, then re-sent with its real colour.
module laser_point_sequencer #(
    parameter int ADDR_W       = 10,
    parameter int DWELL_CYCLES = 100,
    parameter int JUMP_THRESH  = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] num_points,
    output logic [ADDR_W-1:0] pt_addr,
    input  logic [26:0]       pt_data,
    output logic [11:0]       dac_x,
    output logic [11:0]       dac_y,
    output logic [2:0]        dac_rgb,
    output logic              dac_start,
    input  logic              dac_done,
    output logic              busy,
    output logic              frame_done
);

    // Counter only has to reach DWELL_CYCLES-1; keep at least one bit so a
    // zero or one cycle dwell still has a legal counter.
    localparam int CNT_W = (DWELL_CYCLES < 2) ? 1 : $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_LAST =
        CNT_W'((DWELL_CYCLES == 0) ? 0 : DWELL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        WAIT_DONE,
        DWELL
`ifdef BLANK_ON_JUMP_EN
        ,
        BLANK_WAIT
`endif
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] ptAddr_q;
    logic [ADDR_W-1:0] numPts_q;
    logic [11:0]       dacX_q;
    logic [11:0]       dacY_q;
    logic [2:0]        dacRgb_q;
    logic              dacStart_q;
    logic              frameDone_q;
    logic [CNT_W-1:0]  dwellCnt_q;

    logic [11:0] pointX;
    logic [11:0] pointY;
    logic [2:0]  pointRgb;
    logic        lastPoint;
    logic        dwellDone;

    assign pointX   = pt_data[26:15];
    assign pointY   = pt_data[14:3];
    assign pointRgb = pt_data[2:0];

    assign lastPoint = (ptAddr_q == (numPts_q - ADDR_W'(1)));
    assign dwellDone = (dwellCnt_q == DWELL_LAST);

    assign pt_addr    = ptAddr_q;
    assign dac_x      = dacX_q;
    assign dac_y      = dacY_q;
    assign dac_rgb    = dacRgb_q;
    assign dac_start  = dacStart_q;
    assign frame_done = frameDone_q;
    assign busy       = (state_q != IDLE);

`ifdef BLANK_ON_JUMP_EN
    logic [11:0] prevX_q;
    logic [11:0] prevY_q;
    logic [2:0]  trueRgb_q;
    logic        blankPend_q;
    logic [11:0] absDx;
    logic [11:0] absDy;
    logic        isJump;

    // Unsigned per-axis distance from the last point actually output.
    always_comb begin
        absDx  = (pointX >= prevX_q) ? (pointX - prevX_q) : (prevX_q - pointX);
        absDy  = (pointY >= prevY_q) ? (pointY - prevY_q) : (prevY_q - pointY);
        isJump = (int'(absDx) > JUMP_THRESH) || (int'(absDy) > JUMP_THRESH);
    end
`endif

    // Sequencer FSM; every output is a register so the DAC sees clean edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptAddr_q    <= '0;
            numPts_q    <= '0;
            dacX_q      <= '0;
            dacY_q      <= '0;
            dacRgb_q    <= '0;
            dacStart_q  <= 1'b0;
            frameDone_q <= 1'b0;
            dwellCnt_q  <= '0;
`ifdef BLANK_ON_JUMP_EN
            prevX_q     <= '0;
            prevY_q     <= '0;
            trueRgb_q   <= '0;
            blankPend_q <= 1'b0;
`endif
        end else begin
            dacStart_q  <= 1'b0;
            frameDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable && (num_points != '0)) begin
                        numPts_q <= num_points;
                        ptAddr_q <= '0;
                        state_q  <= FETCH;
                    end
                end
                FETCH: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    dacX_q     <= pointX;
                    dacY_q     <= pointY;
`ifdef BLANK_ON_JUMP_EN
                    prevX_q    <= pointX;
                    prevY_q    <= pointY;
                    trueRgb_q  <= pointRgb;
                    if (isJump) begin
                        dacRgb_q    <= 3'd0;
                        blankPend_q <= 1'b1;
                    end else begin
                        dacRgb_q    <= pointRgb;
                        blankPend_q <= 1'b0;
                    end
`else
                    dacRgb_q   <= pointRgb;
`endif
                    dacStart_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (dac_done) begin
                        dwellCnt_q <= '0;
`ifdef BLANK_ON_JUMP_EN
                        if (blankPend_q) begin
                            blankPend_q <= 1'b0;
                            state_q     <= BLANK_WAIT;
                        end else begin
                            state_q <= DWELL;
                        end
`else
                        state_q <= DWELL;
`endif
                    end
                end
                DWELL: begin
                    if (dwellDone) begin
                        dwellCnt_q <= '0;
                        if (lastPoint) begin
                            frameDone_q <= 1'b1;
                            ptAddr_q    <= '0;
                            if (enable && (num_points != '0)) begin
                                numPts_q <= num_points;
                                state_q  <= FETCH;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            ptAddr_q <= ptAddr_q + ADDR_W'(1);
                            state_q  <= FETCH;
                        end
                    end else begin
                        dwellCnt_q <= dwellCnt_q + CNT_W'(1);
                    end
                end
`ifdef BLANK_ON_JUMP_EN
                BLANK_WAIT: begin
                    if (dwellDone) begin
                        dwellCnt_q <= '0;
                        dacRgb_q   <= trueRgb_q;
                        dacStart_q <= 1'b1;
                        state_q    <= SEND;
                    end else begin
                        dwellCnt_q <= dwellCnt_q + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_laser_point_sequencer.sv
// Self-checking bench for laser_point_sequencer: frame table plus
// hand-written reset, spurious-done and (with BLANK_ON_JUMP_EN) blanking
// sequences, all checked against a scoreboard of expected DAC transfers.
module tb_laser_point_sequencer;

    localparam int ADDR_W     = 10;
    localparam int DWELL      = 4;
    localparam int JUMP_LIMIT = 512;
    localparam int DAC_LAT    = 20;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [11:0]       x;
        logic [11:0]       y;
        logic [2:0]        rgb;
    } expPt_t;

    typedef struct {
        int numPoints;
        int dropFrame;
        int dropAddr;
        int expFrames;
    } frameRec_t;

    logic              clk;
    logic              reset;
    logic              enable;
    logic [ADDR_W-1:0] num_points;
    logic [ADDR_W-1:0] pt_addr;
    logic [26:0]       ptData;
    logic [11:0]       dac_x;
    logic [11:0]       dac_y;
    logic [2:0]        dac_rgb;
    logic              dac_start;
    logic              dacDoneModel;
    logic              dacDoneExtra;
    logic              dacDone;
    logic              busy;
    logic              frame_done;

    logic [26:0] mem [0:15];
    expPt_t      expQ [$];

    int testsRun;
    int testsFailed;
    int cycle;
    int doneCnt;
    int startCount;
    int frameDoneCount;
    int stabViol;
    logic [11:0] lastX;
    logic [11:0] lastY;
    logic [2:0]  lastRgb;
`ifdef BLANK_ON_JUMP_EN
    logic [11:0] tbPrevX;
    logic [11:0] tbPrevY;
`endif

    assign dacDone = dacDoneModel | dacDoneExtra;

    laser_point_sequencer #(
        .ADDR_W(ADDR_W),
        .DWELL_CYCLES(DWELL),
        .JUMP_THRESH(JUMP_LIMIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .num_points(num_points),
        .pt_addr(pt_addr),
        .pt_data(ptData),
        .dac_x(dac_x),
        .dac_y(dac_y),
        .dac_rgb(dac_rgb),
        .dac_start(dac_start),
        .dac_done(dacDone),
        .busy(busy),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Point buffer with one cycle of read latency.
    always @(posedge clk) ptData <= mem[pt_addr[3:0]];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

`ifdef BLANK_ON_JUMP_EN
    function automatic int absDiff(input logic [11:0] a, input logic [11:0] b);
        return (a >= b) ? int'(a - b) : int'(b - a);
    endfunction
`endif

    // Queue the transfers one frame of n points should produce.
    task automatic pushFrame(input int n);
        expPt_t e;
        logic [26:0] d;
        for (int a = 0; a < n; a++) begin
            d      = mem[a];
            e.addr = ADDR_W'(a);
            e.x    = d[26:15];
            e.y    = d[14:3];
            e.rgb  = d[2:0];
`ifdef BLANK_ON_JUMP_EN
            if (absDiff(e.x, tbPrevX) > JUMP_LIMIT || absDiff(e.y, tbPrevY) > JUMP_LIMIT) begin
                expPt_t b;
                b     = e;
                b.rgb = 3'd0;
                expQ.push_back(b);
            end
            tbPrevX = e.x;
            tbPrevY = e.y;
`endif
            expQ.push_back(e);
        end
    endtask

    // One clock: DAC driver model, scoreboard pop on dac_start, monitors.
    task automatic tick();
        expPt_t e;
        @(negedge clk);
        cycle++;
        dacDoneModel = 1'b0;
        if (doneCnt != 0) begin
            doneCnt--;
            if (doneCnt == 0) dacDoneModel = 1'b1;
        end
        if (dac_start) begin
            doneCnt = DAC_LAT;
            startCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected dac_start", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("start addr", 32'(pt_addr), 32'(e.addr));
                checkOutput("start x", 32'(dac_x), 32'(e.x));
                checkOutput("start y", 32'(dac_y), 32'(e.y));
                checkOutput("start rgb", 32'(dac_rgb), 32'(e.rgb));
            end
        end
        if (frame_done) frameDoneCount++;
        if (!reset && !dac_start && ({dac_x, dac_y, dac_rgb} !== {lastX, lastY, lastRgb}))
            stabViol++;
        lastX   = dac_x;
        lastY   = dac_y;
        lastRgb = dac_rgb;
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic doReset();
        reset  = 1'b1;
        enable = 1'b0;
        applyStimulus(3);
        reset  = 1'b0;
        expQ.delete();
`ifdef BLANK_ON_JUMP_EN
        tbPrevX = '0;
        tbPrevY = '0;
`endif
    endtask

    task automatic waitStart(input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (dac_start) begin
                at = cycle;
                break;
            end
        end
        if (at < 0) checkOutput("waitStart timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDone(input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (dacDoneModel) begin
                at = cycle;
                break;
            end
        end
        if (at < 0) checkOutput("waitDone timeout", 32'd0, 32'd1);
    endtask

    task automatic waitIdle(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            tick();
            if (!busy) break;
        end
        checkOutput("waitIdle busy", 32'(busy), 32'd0);
    endtask

    initial begin
        frameRec_t recs [6];
        int s1;
        int s2;
        int t;
        int framesBefore;
        int startsBefore;

        recs[0] = '{numPoints: 3, dropFrame: 0, dropAddr: 1, expFrames: 1};
        recs[1] = '{numPoints: 1, dropFrame: 0, dropAddr: 0, expFrames: 1};
        recs[2] = '{numPoints: 3, dropFrame: 1, dropAddr: 0, expFrames: 2};
        recs[3] = '{numPoints: 0, dropFrame: 0, dropAddr: 0, expFrames: 0};
        recs[4] = '{numPoints: 5, dropFrame: 0, dropAddr: 3, expFrames: 1};
        recs[5] = '{numPoints: 2, dropFrame: 2, dropAddr: 1, expFrames: 3};

        testsRun       = 0;
        testsFailed    = 0;
        cycle          = 0;
        doneCnt        = 0;
        startCount     = 0;
        frameDoneCount = 0;
        stabViol       = 0;
        dacDoneModel   = 1'b0;
        dacDoneExtra   = 1'b0;
        num_points     = '0;
        for (int a = 0; a < 16; a++) mem[a] = '0;

        doReset();
        checkOutput("reset pt_addr", 32'(pt_addr), 32'd0);
        checkOutput("reset dac_x", 32'(dac_x), 32'd0);
        checkOutput("reset dac_y", 32'(dac_y), 32'd0);
        checkOutput("reset dac_rgb", 32'(dac_rgb), 32'd0);
        checkOutput("reset dac_start", 32'(dac_start), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset frame_done", 32'(frame_done), 32'd0);

        // Frame table: run, drop enable at a chosen point, let the frame finish.
        for (int r = 0; r < 6; r++) begin
            int  pushed;
            int  firstBusy;
            int  firstStart;
            bit  dropped;
            bit  busySeen;
            for (int a = 0; a < 16; a++) mem[a] = 27'($urandom);
            expQ.delete();
            for (int f = 0; f < recs[r].expFrames; f++) pushFrame(recs[r].numPoints);
            pushed       = expQ.size();
            startsBefore = startCount;
            framesBefore = frameDoneCount;
            stabViol     = 0;
            firstBusy    = -1;
            firstStart   = -1;
            dropped      = 1'b0;
            busySeen     = 1'b0;
            num_points   = ADDR_W'(recs[r].numPoints);
            enable       = 1'b1;
            for (int c = 0; c < 3000; c++) begin
                tick();
                if (busy) busySeen = 1'b1;
                if (busy && firstBusy < 0) firstBusy = cycle;
                if (dac_start && firstStart < 0) firstStart = cycle;
                if (!dropped && dac_start &&
                    (frameDoneCount - framesBefore) == recs[r].dropFrame &&
                    pt_addr == ADDR_W'(recs[r].dropAddr)) begin
                    enable     = 1'b0;
                    num_points = ADDR_W'(9);
                    dropped    = 1'b1;
                end
                if (recs[r].numPoints == 0 && c == 30) begin
                    enable  = 1'b0;
                    dropped = 1'b1;
                end
                if (dropped && !busy) break;
            end
            checkOutput($sformatf("rec%0d idle", r), 32'(busy), 32'd0);
            checkOutput($sformatf("rec%0d starts", r), 32'(startCount - startsBefore), 32'(pushed));
            checkOutput($sformatf("rec%0d frame_done", r), 32'(frameDoneCount - framesBefore),
                        32'(recs[r].expFrames));
            checkOutput($sformatf("rec%0d queue left", r), 32'(expQ.size()), 32'd0);
            checkOutput($sformatf("rec%0d wrap addr", r), 32'(pt_addr), 32'd0);
            checkOutput($sformatf("rec%0d dac hold", r), 32'(stabViol), 32'd0);
            if (recs[r].numPoints != 0)
                checkOutput($sformatf("rec%0d latency", r), 32'(firstStart - firstBusy), 32'd2);
            else
                checkOutput($sformatf("rec%0d busy seen", r), 32'(busySeen), 32'd0);
            applyStimulus(3);
        end

        // Spurious dac_done during DWELL must not disturb address or count.
        doReset();
        mem[0] = {12'd100, 12'd100, 3'd3};
        mem[1] = {12'd120, 12'd90, 3'd6};
        pushFrame(2);
        framesBefore = frameDoneCount;
        num_points   = ADDR_W'(2);
        enable       = 1'b1;
        waitStart(50, s1);
        waitDone(50, t);
        tick();
        dacDoneExtra = 1'b1;
        tick();
        dacDoneExtra = 1'b0;
        checkOutput("spurious addr hold", 32'(pt_addr), 32'd0);
        waitStart(50, s2);
        checkOutput("dwell gap", 32'(s2 - t), 32'(DWELL + 3));
        enable = 1'b0;
        waitIdle(200);
        checkOutput("spurious frames", 32'(frameDoneCount - framesBefore), 32'd1);
        checkOutput("spurious queue left", 32'(expQ.size()), 32'd0);

        // Reset while waiting on the DAC; its late done must be ignored.
        doReset();
        mem[0] = {12'd300, 12'd200, 3'd1};
        mem[1] = {12'd310, 12'd210, 3'd2};
        mem[2] = {12'd320, 12'd220, 3'd4};
        pushFrame(1);
        num_points = ADDR_W'(3);
        enable     = 1'b1;
        waitStart(50, s1);
        applyStimulus(5);
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        checkOutput("reset in WAIT_DONE busy", 32'(busy), 32'd0);
        reset = 1'b0;
        begin
            bit busySeen;
            busySeen     = 1'b0;
            startsBefore = startCount;
            framesBefore = frameDoneCount;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (busy) busySeen = 1'b1;
            end
            checkOutput("stale done busy", 32'(busySeen), 32'd0);
            checkOutput("stale done starts", 32'(startCount - startsBefore), 32'd0);
            checkOutput("stale done frames", 32'(frameDoneCount - framesBefore), 32'd0);
            checkOutput("post reset dac_x", 32'(dac_x), 32'd0);
            checkOutput("post reset dac_y", 32'(dac_y), 32'd0);
            checkOutput("post reset dac_rgb", 32'(dac_rgb), 32'd0);
            checkOutput("post reset pt_addr", 32'(pt_addr), 32'd0);
        end

`ifdef BLANK_ON_JUMP_EN
        // A large jump is sent dark, held one dwell, then sent lit.
        doReset();
        mem[0] = {12'd0, 12'd0, 3'd7};
        mem[1] = {12'd4000, 12'd0, 3'd5};
        pushFrame(2);
        checkOutput("blank queued", 32'(expQ.size()), 32'd3);
        framesBefore = frameDoneCount;
        num_points   = ADDR_W'(2);
        enable       = 1'b1;
        waitStart(50, s1);
        enable = 1'b0;
        waitStart(100, s1);
        waitDone(50, t);
        waitStart(50, s2);
        checkOutput("blank gap", 32'(s2 - t), 32'(DWELL + 1));
        waitIdle(200);
        checkOutput("blank frames", 32'(frameDoneCount - framesBefore), 32'd1);
        checkOutput("blank queue left", 32'(expQ.size()), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/laser_point_sequencer.md
LASER_POINT_SEQUENCER -- requirements
Module: laser_point_sequencer

Interface
REQ-001 Parameter ADDR_W, default 10, point-buffer address width.
REQ-002 Parameter DWELL_CYCLES, default 100, clk cycles held on each point after the DAC transfer completes.
REQ-003 Parameter JUMP_THRESH, default 512, per-axis jump size (LSB) that triggers blanking.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  run frames while high.
REQ-007 num_points  input  ADDR_W  points per frame; 0 means no output.
REQ-008 pt_addr  output  ADDR_W  point-buffer read address.
REQ-009 pt_data  input  27  {x[26:15], y[14:3], rgb[2:0]}; valid exactly 1 cycle after pt_addr.
REQ-010 dac_x, dac_y  output  12 each  coordinates to DAC driver.
REQ-011 dac_rgb  output  3  laser colour to DAC driver.
REQ-012 dac_start  output  1  one-cycle pulse that launches a DAC transfer.
REQ-013 dac_done  input  1  one-cycle pulse from DAC driver on transfer completion.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 frame_done  output  1  one-cycle pulse after the last point's dwell ends.

Function
REQ-016 States SHALL be IDLE, FETCH, LOAD, SEND, WAIT_DONE, DWELL, plus BLANK_WAIT when BLANK_ON_JUMP_EN is defined.
REQ-017 IDLE->FETCH when enable=1 and num_points!=0; pt_addr=0 on entry.
REQ-018 FETCH holds pt_addr for one cycle; LOAD captures pt_data into dac_x/dac_y/dac_rgb registers.
REQ-019 SEND asserts dac_start for exactly one cycle, then WAIT_DONE; dac_x/y/rgb SHALL stay stable from SEND until the next LOAD.
REQ-020 WAIT_DONE->DWELL on dac_done; dac_done in any other state SHALL be ignored.
REQ-021 DWELL counts DWELL_CYCLES cycles (0 means exit on the first DWELL cycle), then: if pt_addr==num_points-1, pulse frame_done, pt_addr wraps to 0, go FETCH if enable else IDLE; otherwise pt_addr+1, go FETCH.
REQ-022 enable deasserting mid-frame SHALL NOT abort; the frame finishes, then IDLE.
REQ-023 num_points is sampled on IDLE->FETCH and at each wrap; mid-frame changes have no effect.
REQ-024 Point-to-point latency: dac_start SHALL assert exactly 3 cycles after FETCH entry (FETCH, LOAD, SEND), non-blanked path.
REQ-025 Jump compare uses unsigned 12-bit absolute difference against the previous point; the first point of a frame SHALL compare against the last point output (0,0 after reset).

Reset
REQ-026 On reset: state=IDLE, pt_addr=0, dac_x=dac_y=0, dac_rgb=0, dac_start=0, busy=0, frame_done=0, dwell counter=0, previous point=(0,0).
REQ-027 Reset mid-operation, including WAIT_DONE, SHALL return to IDLE next cycle; a later stale dac_done SHALL be ignored.

Configuration
REQ-028 Macro BLANK_ON_JUMP_EN: when defined, a point with |dx|>JUMP_THRESH or |dy|>JUMP_THRESH SHALL first be sent with dac_rgb=0, wait for dac_done, then BLANK_WAIT for DWELL_CYCLES, then be re-sent via SEND with its true rgb. When undefined, every point is sent once with its stored rgb and the BLANK_WAIT state is absent.

Verification
REQ-029 num_points=3, DWELL_CYCLES=4, model DAC done 20 cycles after start -> three dac_start pulses at addresses 0,1,2 with matching x/y/rgb; one frame_done; wrap to address 0.
REQ-030 enable=0 at point 1 of 3 -> points 1 and 2 still sent, frame_done pulses, busy falls, no further dac_start.
REQ-031 num_points=0, enable=1 -> remains IDLE, dac_start never asserts, busy=0.
REQ-032 reset asserted in WAIT_DONE, then dac_done pulse -> IDLE, all outputs at reset values, no DWELL entry.
REQ-033 BLANK_ON_JUMP_EN defined, points (0,0,rgb=7) then (4000,0,rgb=5) -> second point sent twice: first with rgb=0, then with rgb=5, separated by DWELL_CYCLES.
REQ-034 Spurious dac_done in DWELL -> no state or address change; dwell count unaffected.
